// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding IF/M memory bus arbiter, data-first priority
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IF_Req,
    input  logic [31:0] IF_Addr,
    output logic [31:0] IF_RData,
    output logic        IF_Ready,
    output logic        IF_Stall,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WData,
    input  logic [3:0]  M_ByteEn,
    output logic [31:0] M_RData,
    output logic        M_Ready,
    output logic        M_Stall,
    output logic        Mem_Req,
    output logic        Mem_Wr,
    output logic [29:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic [3:0]  Mem_BE,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData,
    output logic        Bus_Err
);

    typedef enum logic [2:0] {IDLE, D_WAIT, D_DONE, I_WAIT, I_DONE} state_t;

    state_t state, state_next;
    logic   m_req;
    logic   load_d, load_i, cap_d, cap_i;
    logic   tmo_hit, tmo_fire;
    logic   unused_addr_lsbs;

    assign m_req            = M_MemRead | M_MemWrite;
    assign unused_addr_lsbs = &{1'b0, IF_Addr[1:0], M_Addr[1:0]};

    assign Mem_Req  = (state == D_WAIT) || (state == I_WAIT);
    assign M_Ready  = (state == D_DONE);
    assign IF_Ready = (state == I_DONE);
    assign M_Stall  = m_req  & (state != D_DONE);
    assign IF_Stall = IF_Req & (state != I_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_d     = 1'b0;
        load_i     = 1'b0;
        cap_d      = 1'b0;
        cap_i      = 1'b0;
        tmo_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (m_req) begin
                    load_d     = 1'b1;
                    state_next = D_WAIT;
                end else if (IF_Req) begin
                    load_i     = 1'b1;
                    state_next = I_WAIT;
                end
            end
            D_WAIT: begin
                if (Mem_Ack) begin
                    cap_d      = 1'b1;
                    state_next = D_DONE;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = D_DONE;
                end
            end
            I_WAIT: begin
                if (Mem_Ack) begin
                    cap_i      = 1'b1;
                    state_next = I_DONE;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = I_DONE;
                end
            end
            D_DONE:  state_next = IDLE;
            I_DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Mem_Addr  <= '0;
            Mem_Wr    <= 1'b0;
            Mem_WData <= '0;
            Mem_BE    <= '0;
            M_RData   <= '0;
            IF_RData  <= '0;
        end else begin
            if (load_d) begin
                Mem_Addr  <= M_Addr[31:2];
                Mem_Wr    <= M_MemWrite;
                Mem_WData <= M_WData;
                Mem_BE    <= M_MemWrite ? M_ByteEn : 4'hF;
            end else if (load_i) begin
                Mem_Addr  <= IF_Addr[31:2];
                Mem_Wr    <= 1'b0;
                Mem_BE    <= 4'hF;
            end
            if (cap_d && !Mem_Wr) begin
                M_RData <= Mem_RData;
            end
            if (cap_i) begin
                IF_RData <= Mem_RData;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    assign tmo_hit = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            Bus_Err  <= 1'b0;
        end else begin
            if (load_d || load_i) begin
                wait_cnt <= '0;
            end else if (Mem_Req && !Mem_Ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            Bus_Err <= tmo_fire;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign Bus_Err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic [31:0] IF_RData;
    logic        IF_Ready;
    logic        IF_Stall;
    logic        M_MemRead;
    logic        M_MemWrite;
    logic [31:0] M_Addr;
    logic [31:0] M_WData;
    logic [3:0]  M_ByteEn;
    logic [31:0] M_RData;
    logic        M_Ready;
    logic        M_Stall;
    logic        Mem_Req;
    logic        Mem_Wr;
    logic [29:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [3:0]  Mem_BE;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;
    logic        Bus_Err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_if_rdata;
    logic [31:0] exp_m_rdata;

    always #5 clock = ~clock;

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .IF_Req     (IF_Req),
        .IF_Addr    (IF_Addr),
        .IF_RData   (IF_RData),
        .IF_Ready   (IF_Ready),
        .IF_Stall   (IF_Stall),
        .M_MemRead  (M_MemRead),
        .M_MemWrite (M_MemWrite),
        .M_Addr     (M_Addr),
        .M_WData    (M_WData),
        .M_ByteEn   (M_ByteEn),
        .M_RData    (M_RData),
        .M_Ready    (M_Ready),
        .M_Stall    (M_Stall),
        .Mem_Req    (Mem_Req),
        .Mem_Wr     (Mem_Wr),
        .Mem_Addr   (Mem_Addr),
        .Mem_WData  (Mem_WData),
        .Mem_BE     (Mem_BE),
        .Mem_Ack    (Mem_Ack),
        .Mem_RData  (Mem_RData),
        .Bus_Err    (Bus_Err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_txn(input bit ifr, input bit mr, input bit mw,
                           input logic [31:0] ifa, input logic [31:0] ma,
                           input logic [31:0] wd, input logic [3:0] be,
                           input int delay, input bit spur);
        bit          data, timed_out;
        int          waits;
        logic [29:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] rd;
        IF_Req     = ifr;
        IF_Addr    = ifa;
        M_MemRead  = mr;
        M_MemWrite = mw;
        M_Addr     = ma;
        M_WData    = wd;
        M_ByteEn   = be;
        Mem_Ack    = spur;
        Mem_RData  = $urandom;
        data       = mr | mw;
        @(negedge clock);
        check("idle_mem_req", Mem_Req, 0);
        check("idle_m_stall", M_Stall, data);
        check("idle_if_stall", IF_Stall, ifr);
        check("idle_ready", {M_Ready, IF_Ready}, 0);
        step();
        Mem_Ack = 1'b0;
        if (!data && !ifr) begin
            @(negedge clock);
            check("noreq_mem_req", Mem_Req, 0);
            check("noreq_ready", {M_Ready, IF_Ready}, 0);
            step();
            return;
        end
        exp_addr  = data ? ma[31:2] : ifa[31:2];
        exp_be    = (data && mw) ? be : 4'hF;
        timed_out = TMO_EN && (delay >= TMO);
        waits     = timed_out ? TMO : delay + 1;
        rd        = '0;
        for (int k = 0; k < waits; k++) begin
            Mem_Ack   = !timed_out && (k == delay);
            rd        = $urandom;
            Mem_RData = rd;
            @(negedge clock);
            check("wait_mem_req", Mem_Req, 1);
            check("wait_addr", Mem_Addr, exp_addr);
            check("wait_wr", Mem_Wr, data & mw);
            check("wait_be", Mem_BE, exp_be);
            if (data && mw) check("wait_wdata", Mem_WData, wd);
            check("wait_stall", data ? M_Stall : IF_Stall, 1);
            check("wait_ready", {M_Ready, IF_Ready}, 0);
            step();
        end
        Mem_Ack = 1'b0;
        if (!timed_out) begin
            if (data && !mw) exp_m_rdata = rd;
            if (!data) exp_if_rdata = rd;
        end
        @(negedge clock);
        check("done_mem_req", Mem_Req, 0);
        check("done_m_ready", M_Ready, data);
        check("done_if_ready", IF_Ready, !data);
        check("done_m_rdata", M_RData, exp_m_rdata);
        check("done_if_rdata", IF_RData, exp_if_rdata);
        check("done_m_stall", M_Stall, 0);
        check("done_if_stall", IF_Stall, data ? ifr : 1'b0);
        check("done_bus_err", Bus_Err, timed_out);
        step();
        if (data) begin
            M_MemRead  = 1'b0;
            M_MemWrite = 1'b0;
        end else begin
            IF_Req = 1'b0;
        end
    endtask

    initial begin
        bit          pend_if, ifr, mr, mw;
        logic [31:0] pend_ifa;
        reset      = 1'b1;
        IF_Req     = 1'b0;
        IF_Addr    = '0;
        M_MemRead  = 1'b0;
        M_MemWrite = 1'b0;
        M_Addr     = '0;
        M_WData    = '0;
        M_ByteEn   = '0;
        Mem_Ack    = 1'b0;
        Mem_RData  = '0;
        exp_if_rdata = '0;
        exp_m_rdata  = '0;
        step();
        @(negedge clock);
        check("rst_mem_req", Mem_Req, 0);
        check("rst_mem_wr", Mem_Wr, 0);
        check("rst_bus_err", Bus_Err, 0);
        check("rst_ready", {M_Ready, IF_Ready}, 0);
        check("rst_mem_addr", Mem_Addr, 0);
        check("rst_mem_wdata", Mem_WData, 0);
        check("rst_mem_be", Mem_BE, 0);
        check("rst_m_rdata", M_RData, 0);
        check("rst_if_rdata", IF_RData, 0);
        step();
        reset = 1'b0;
        step();

        run_txn(1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 4'h0, 0, 0);
        run_txn(1, 0, 1, 32'h0000_0300, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 0, 0);
        run_txn(1, 0, 0, 32'h0000_0300, 32'h0, 32'h0, 4'h0, 0, 0);
        run_txn(0, 1, 0, 32'h0, 32'h0000_1234, 32'h0, 4'h0, 5, 0);
        run_txn(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 1);

        M_MemRead = 1'b1;
        M_Addr    = 32'h0000_0A00;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_mem_req", Mem_Req, 0);
        check("rst_mid_m_ready", M_Ready, 0);
        M_MemRead = 1'b0;
        step();
        reset = 1'b0;
        exp_m_rdata  = '0;
        exp_if_rdata = '0;
        @(negedge clock);
        check("post_rst_mem_req", Mem_Req, 0);
        check("post_rst_m_ready", M_Ready, 0);
        check("post_rst_m_rdata", M_RData, 0);
        step();
        run_txn(0, 1, 0, 32'h0, 32'h0000_0040, 32'h0, 4'h0, 1, 0);

        pend_if  = 1'b0;
        pend_ifa = '0;
        for (int i = 0; i < 200; i++) begin
            ifr = pend_if ? 1'b1 : 1'($urandom_range(0, 1));
            if (!pend_if) pend_ifa = $urandom;
            mr = ($urandom_range(0, 2) == 0);
            mw = ($urandom_range(0, 2) == 0);
            run_txn(ifr, mr, mw, pend_ifa, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 6), 1'($urandom_range(0, 1)));
            pend_if = ifr && (mr || mw);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
